// File: rtl/fir_decimator.sv
// Polyphase FIR decimator: circular delay line, one time-shared MAC pass per DOWNFACTOR accepted samples.
// o_valid rises NTAPS+3 cycles after the trigger cycle; o_ready is low for the NTAPS+2 busy cycles of a pass.
module fir_decimator #(
    parameter int IW         = 16,
    parameter int TW         = IW,
    parameter int OW         = IW,
    parameter int NTAPS      = 32,
    parameter int DOWNFACTOR = 4,
    parameter int SHIFT      = TW - 1
) (
    input  logic                     i_clk,
    input  logic                     i_reset_n,
    input  logic                     i_valid,
    output logic                     o_ready,
    input  logic signed [IW-1:0]     i_sample,
    input  logic                     i_sync,
    input  logic                     i_tap_wr,
    input  logic [$clog2(NTAPS)-1:0] i_tap_addr,
    input  logic signed [TW-1:0]     i_tap,
    output logic                     o_valid,
    output logic signed [OW-1:0]     o_sample,
    output logic                     o_overflow
);
    localparam int AW = IW + TW + $clog2(NTAPS);
    localparam int LW = $clog2(NTAPS);
    localparam int PW = (DOWNFACTOR > 1) ? $clog2(DOWNFACTOR) : 1;
    localparam int QW = AW - SHIFT + 1;
    localparam logic signed [QW-1:0] SAT_MAX = QW'((longint'(1) <<< (OW - 1)) - 1);
    localparam logic signed [QW-1:0] SAT_MIN = ~SAT_MAX;

    typedef enum logic [1:0] {IDLE, MAC, DRAIN, ROUND} state_t;

    state_t                  state, state_nxt;
    logic [LW-1:0]           wr_ptr, tap_idx, rd_idx;
    logic [PW-1:0]           phase;
    logic signed [IW-1:0]    xmem [NTAPS];
    logic signed [TW-1:0]    hmem [NTAPS];
    logic signed [IW+TW-1:0] prod;
    logic signed [AW-1:0]    acc;
    logic                    accept, trigger, last_tap;
    logic signed [QW-1:0]    q_floor, q_rnd;
    logic                    sat_hi, sat_lo;
    logic signed [OW-1:0]    sat_val;

    assign o_ready  = (state == IDLE);
    assign accept   = i_valid && o_ready;
    assign trigger  = accept && !i_sync && (phase == PW'(DOWNFACTOR - 1));
    assign last_tap = (tap_idx == LW'(NTAPS - 1));
    // Nothing is written during a pass, so the trigger sample sits just behind wr_ptr.
    assign rd_idx   = wr_ptr - LW'(1) - tap_idx;

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (trigger) state_nxt = MAC;
            MAC:     if (last_tap) state_nxt = DRAIN;
            DRAIN:   state_nxt = ROUND;
            ROUND:   state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Floor shift, then round half to even on the discarded bits.
    assign q_floor = QW'(acc >>> SHIFT);

    generate
        if (SHIFT > 0) begin : g_round
            localparam logic [AW-1:0] HALF = AW'(1) << (SHIFT - 1);
            logic [SHIFT-1:0] frac;
            logic             round_up;
            assign frac     = acc[SHIFT-1:0];
            assign round_up = (frac > HALF[SHIFT-1:0]) ||
                              ((frac == HALF[SHIFT-1:0]) && q_floor[0]);
            assign q_rnd    = q_floor + QW'(round_up);
        end else begin : g_noround
            assign q_rnd = q_floor;
        end
    endgenerate

    assign sat_hi  = (q_rnd > SAT_MAX);
    assign sat_lo  = (q_rnd < SAT_MIN);
    assign sat_val = sat_hi ? OW'(SAT_MAX) : (sat_lo ? OW'(SAT_MIN) : OW'(q_rnd));

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state      <= IDLE;
            wr_ptr     <= '0;
            phase      <= '0;
            tap_idx    <= '0;
            prod       <= '0;
            acc        <= '0;
            o_valid    <= 1'b0;
            o_sample   <= '0;
            o_overflow <= 1'b0;
            for (int i = 0; i < NTAPS; i++) begin
                xmem[i] <= '0;
                hmem[i] <= '0;
            end
        end else begin
            state   <= state_nxt;
            o_valid <= (state == ROUND);

            if (accept) begin
                xmem[wr_ptr] <= i_sample;
                wr_ptr       <= wr_ptr + LW'(1);
                if (i_sync)
                    phase <= PW'(1);
                else if (phase == PW'(DOWNFACTOR - 1))
                    phase <= '0;
                else
                    phase <= phase + PW'(1);
            end

            // Coefficients are frozen for the whole pass.
            if (o_ready && i_tap_wr)
                hmem[i_tap_addr] <= i_tap;

            if (state == MAC) begin
                prod    <= (IW+TW)'(hmem[tap_idx]) * (IW+TW)'(xmem[rd_idx]);
                tap_idx <= tap_idx + LW'(1);
            end

            if ((state == MAC) && (tap_idx == LW'(1)))
                acc <= AW'(prod);
            else if (((state == MAC) && (tap_idx > LW'(1))) || (state == DRAIN))
                acc <= acc + AW'(prod);

            if (state == ROUND) begin
                o_sample <= sat_val;
                if (sat_hi || sat_lo)
                    o_overflow <= 1'b1;
            end
        end
    end
endmodule
